emulador_sensores: RTL and testbench

//  Stimulus side of the parking-lot a/b sensor interface.
//  - Accepts queued "car passes" commands: ingress or egress.
//  - For each command, drives the two-sensor Gray sequence a car produces while crossing the gate.
//  - Output feeds the ingress/egress detection FSM directly, without debounce; used for board demo and self-test.

---
 rtl/emulador_sensores.sv | 111 +++++++++++
 tb/tb_emulador_sensores.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/emulador_sensores.sv
// emulador_sensores: queued ingress/egress car commands replayed as the a/b sensor Gray sequence.
// A small FIFO feeds a phase FSM whose registered outputs drive the detector directly.
module emulador_sensores #(
    parameter int PHASE_CYCLES = 4,
    parameter int GAP_CYCLES   = 2,
    parameter int DEPTH        = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cmd_valid,
    input  logic                       cmd_dir,
    output logic                       cmd_ready,
    output logic                       sensor_a,
    output logic                       sensor_b,
    output logic                       busy,
    output logic                       done,
    output logic                       done_dir,
    output logic [$clog2(DEPTH+1)-1:0] pending
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int TW = $clog2((PHASE_CYCLES > GAP_CYCLES ? PHASE_CYCLES : GAP_CYCLES) + 1);

    typedef enum logic [2:0] {IDLE, PH1, PH2, PH3, GAP} state_t;

    state_t          state_q, state_d;
    logic [TW-1:0]   tmr_q, tmr_d;
    logic            dir_q, dir_d;
    logic [1:0]      ab_q, ab_d;
    logic            done_q, done_d;
    logic            done_dir_q;
    logic [DEPTH-1:0] mem_q;
    logic [AW-1:0]   wr_q, rd_q;
    logic [CW-1:0]   cnt_q;
    logic            full, push, pop;

    assign full      = cnt_q == CW'(DEPTH);
    assign cmd_ready = !full;
    assign push      = cmd_valid && !full;
    assign pop       = state_q == IDLE && cnt_q != '0;
    assign pending   = cnt_q;
    assign busy      = state_q != IDLE;
    assign sensor_a  = ab_q[1];
    assign sensor_b  = ab_q[0];
    assign done      = done_q;
    assign done_dir  = done_dir_q;

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push) begin
                mem_q[wr_q] <= cmd_dir;
                wr_q        <= wr_q + 1'b1;
            end
            if (pop)
                rd_q <= rd_q + 1'b1;
            cnt_q <= cnt_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            tmr_q      <= '0;
            dir_q      <= 1'b0;
            ab_q       <= 2'b00;
            done_q     <= 1'b0;
            done_dir_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            tmr_q      <= tmr_d;
            dir_q      <= dir_d;
            ab_q       <= ab_d;
            done_q     <= done_d;
            done_dir_q <= done_d && dir_d;
        end
    end

    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        dir_d   = dir_q;
        case (state_q)
            IDLE: if (pop) begin
                state_d = PH1;
                tmr_d   = TW'(PHASE_CYCLES - 1);
                dir_d   = mem_q[rd_q];
            end
            PH1, PH2, PH3: if (tmr_q == '0) begin
                state_d = state_q == PH1 ? PH2 : state_q == PH2 ? PH3 : GAP;
                tmr_d   = state_q == PH3 ? TW'(GAP_CYCLES - 1) : TW'(PHASE_CYCLES - 1);
            end else begin
                tmr_d = tmr_q - 1'b1;
            end
            GAP: if (tmr_q == '0) state_d = IDLE; else tmr_d = tmr_q - 1'b1;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered from the next state so the pattern appears on the entering edge.
    always_comb begin
        ab_d   = state_d == PH1 ? (dir_d ? 2'b01 : 2'b10) :
                 state_d == PH2 ? 2'b11 :
                 state_d == PH3 ? (dir_d ? 2'b10 : 2'b01) : 2'b00;
        done_d = state_q == PH3 && state_d == GAP;
    end
endmodule

// File: tb/tb_emulador_sensores.sv
// tb_emulador_sensores: directed tests with a done_dir scoreboard, Gray-step monitor and detector model.
module tb_emulador_sensores;
    logic       clk = 1'b0;
    logic       rst, cmd_valid, cmd_dir;
    logic       cmd_ready, sensor_a, sensor_b, busy, done, done_dir;
    logic [2:0] pending;

    int         checks = 0, errors = 0, cycle = 0, n_in = 0, n_eg = 0;
    logic       q_dir[$];
    int         done_t[$];
    logic [1:0] hist[$];
    logic [1:0] prev_ab = 2'b00;
    logic [5:0] seq = '0;

    always #5 clk = ~clk;

    emulador_sensores #(.PHASE_CYCLES(4), .GAP_CYCLES(2), .DEPTH(4)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_dir(cmd_dir),
        .cmd_ready(cmd_ready), .sensor_a(sensor_a), .sensor_b(sensor_b),
        .busy(busy), .done(done), .done_dir(done_dir), .pending(pending)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock, then monitor: single-bit steps, detector model, done_dir scoreboard.
    task automatic cyc();
        logic       was_rst;
        logic [1:0] ab;
        was_rst = rst;
        @(posedge clk);
        #1;
        cycle++;
        ab = {sensor_a, sensor_b};
        hist.push_back(ab);
        if (was_rst) seq = '0;
        else chk("one_bit", 32'($countones(ab ^ prev_ab) <= 1), 1);
        if (!was_rst && ab != prev_ab) begin
            if (ab == 2'b00) begin
                if (seq == 6'b10_11_01) n_in++;
                if (seq == 6'b01_11_10) n_eg++;
                seq = '0;
            end else begin
                seq = {seq[3:0], ab};
            end
        end
        prev_ab = ab;
        if (done) begin
            done_t.push_back(cycle);
            if (q_dir.size() == 0) chk("done_unexpected", 1, 0);
            else chk("done_dir", done_dir, q_dir.pop_front());
        end
    endtask

    task automatic send(input logic d);
        logic rdy;
        bit   ok;
        ok = 0;
        cmd_valid = 1'b1;
        cmd_dir = d;
        for (int i = 0; i < 100 && !ok; i++) begin
            rdy = cmd_ready;
            cyc();
            if (rdy) begin
                q_dir.push_back(d);
                ok = 1;
            end
        end
        cmd_valid = 1'b0;
        if (!ok) chk("send_timeout", 0, 1);
    endtask

    function automatic logic [1:0] exp_ab(input int n, input logic d);
        if (n >= 1 && n <= 4) return d ? 2'b01 : 2'b10;
        if (n >= 5 && n <= 8) return 2'b11;
        if (n >= 9 && n <= 12) return d ? 2'b10 : 2'b01;
        return 2'b00;
    endfunction

    task automatic play(input logic d);
        for (int n = 1; n <= 15; n++) begin
            cyc();
            chk("ab", {sensor_a, sensor_b}, exp_ab(n, d));
            chk("done", done, n == 13);
            chk("busy", busy, n <= 14);
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 600 && (q_dir.size() != 0 || busy); i++) cyc();
        chk("drain", q_dir.size() == 0 && !busy, 1);
    endtask

    initial begin
        int runs, z;
        bit seen;
        rst = 1'b1;
        cmd_valid = 1'b0;
        cmd_dir = 1'b0;
        cyc();
        chk("rst_ab", {sensor_a, sensor_b}, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_done_dir", done_dir, 0);
        chk("rst_pending", pending, 0);
        chk("rst_ready", cmd_ready, 1);
        cyc();
        rst = 1'b0;

        // single ingress
        send(1'b0);
        chk("t1_pending", pending, 1);
        chk("t1_ab0", {sensor_a, sensor_b}, 0);
        chk("t1_busy0", busy, 0);
        play(1'b0);

        // single egress through the detector model
        n_in = 0;
        n_eg = 0;
        send(1'b1);
        play(1'b1);
        chk("t2_egress", n_eg, 1);
        chk("t2_ingress", n_in, 0);

        // five back-to-back commands
        done_t.delete();
        send(1'b0); send(1'b1); send(1'b1); send(1'b0); send(1'b1);
        chk("t3_pending", pending, 4);
        chk("t3_ready", cmd_ready, 0);
        drain();
        chk("t3_dones", done_t.size(), 5);
        for (int i = 1; i < done_t.size(); i++) chk("t3_spacing", done_t[i] - done_t[i-1], 15);

        // alternating directions, 00 windows between cars
        hist.delete();
        done_t.delete();
        send(1'b0); send(1'b1); send(1'b0); send(1'b1);
        drain();
        chk("t4_dones", done_t.size(), 4);
        runs = 0;
        z = 0;
        seen = 0;
        foreach (hist[i]) begin
            if (hist[i] == 2'b00) z++;
            else begin
                if (seen && z > 0) begin
                    chk("t4_gap", z, 3);
                    runs++;
                end
                seen = 1;
                z = 0;
            end
        end
        chk("t4_runs", runs, 3);

        // reset during PH2 with two pending
        send(1'b0); send(1'b1); send(1'b1);
        cyc(); cyc(); cyc();
        chk("t5_ph2", {sensor_a, sensor_b}, 2'b11);
        chk("t5_pending2", pending, 2);
        rst = 1'b1;
        q_dir.delete();
        cyc();
        rst = 1'b0;
        chk("t5_ab", {sensor_a, sensor_b}, 0);
        chk("t5_pending", pending, 0);
        chk("t5_busy", busy, 0);
        chk("t5_done", done, 0);
        chk("t5_ready", cmd_ready, 1);
        for (int i = 0; i < 10; i++) begin
            cyc();
            chk("t5_no_done", done, 0);
        end
        send(1'b1);
        play(1'b1);

        // simultaneous push and pop, order kept across wrap
        send(1'b0); send(1'b1); send(1'b0);
        for (int k = 0; k < 6; k++) begin
            for (int i = 0; i < 100 && !(!busy && pending == 2); i++) cyc();
            chk("t6_wait", !busy && pending == 2, 1);
            send(1'($urandom_range(0, 1)));
            chk("t6_pending", pending, 2);
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
